// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared framer types, constants and CP clamp helper
// Contents: tx_state_e (IDLE/FILL/CP/BODY), AXIS_TKEEP, config field widths,
//           clamp_cp() which limits the cyclic prefix to one symbol.
package ofdm_pkg;

    localparam int NFFT_W = 12;
    localparam int SYM_W  = 4;

    localparam logic [3:0] AXIS_TKEEP = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        CP   = 2'd2,
        BODY = 2'd3
    } tx_state_e;

    function automatic logic [NFFT_W-1:0] clamp_cp(input logic [NFFT_W-1:0] cp_len,
                                                   input logic [NFFT_W-1:0] nfft);
        return (cp_len > nfft) ? nfft : cp_len;
    endfunction

endpackage

// File: rtl/tx_framer_if.sv
// rtl/tx_framer_if.sv - symbol buffer access bundle between framer and sdp_ram
// Signals: wr_en/wr_addr/wr_data (write port), rd_en/rd_addr (read request),
//          rd_data (registered read data, valid the cycle after rd_en).
// Modports: master = framer side, slave = RAM side.
interface tx_framer_if #(
    parameter int ADDR_W = 12
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/tx_framer_sdp_ram.sv
// rtl/tx_framer_sdp_ram.sv - simple dual-port 32-bit x 2^ADDR_W symbol buffer
// Ports: clk; bus (tx_framer_if.slave). One write port, one read port with a
// single registered read stage. rd_data only updates when rd_en is high, so it
// doubles as the framer's output holding register during back-pressure.
// Contents are never reset.
module sdp_ram #(
    parameter int ADDR_W = 12
) (
    input logic         clk,
    tx_framer_if.slave  bus
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        if (bus.rd_en) begin
            bus.rd_data <= mem[bus.rd_addr];
        end
    end

endmodule

// File: rtl/tx_framer.sv
// rtl/tx_framer.sv - OFDM TX framer: buffers one IFFT symbol, emits CP + body
// Ports: axis_aclk/axis_rst (async, active-high); s_axis_* sample input;
//        m_axis_* framed output (tkeep constant 4'hF); i_nfft, i_cp_len,
//        i_symbols frame configuration sampled on IDLE exit.
// Optional: define TX_FRAMER_DEBUG_EN to add o_dbg_state / o_dbg_sym_cnt.
module tx_framer
    import ofdm_pkg::*;
#(
    parameter int G_ADDR_W = 12
) (
    input  logic              axis_aclk,
    input  logic              axis_rst,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [3:0]        m_axis_tkeep,
    input  logic [NFFT_W-1:0] i_nfft,
    input  logic [NFFT_W-1:0] i_cp_len,
    input  logic [SYM_W-1:0]  i_symbols
`ifdef TX_FRAMER_DEBUG_EN
    ,
    output logic [1:0]        o_dbg_state,
    output logic [SYM_W-1:0]  o_dbg_sym_cnt
`endif
);

    tx_state_e         state_q, state_d;
    logic [NFFT_W-1:0] nfft_q, nfft_d;
    logic [NFFT_W-1:0] cp_q, cp_d;
    logic [SYM_W-1:0]  sym_last_q, sym_last_d;
    logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [NFFT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [NFFT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              issue_done_q, issue_done_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    logic              adv;
    logic              wr_en;
    logic              rd_en;
    logic [NFFT_W-1:0] rd_ptr;

    tx_framer_if #(.ADDR_W(G_ADDR_W)) ram_bus ();

    sdp_ram #(
        .ADDR_W (G_ADDR_W)
    ) u_sdp_ram (
        .clk (axis_aclk),
        .bus (ram_bus.slave)
    );

    assign ram_bus.wr_en   = wr_en;
    assign ram_bus.wr_addr = G_ADDR_W'(wr_cnt_q);
    assign ram_bus.wr_data = s_axis_tdata;
    assign ram_bus.rd_en   = rd_en;
    assign ram_bus.rd_addr = G_ADDR_W'(rd_ptr);

    // The RAM read register is the output stage; masking with valid_q gives
    // a zero data bus after reset without resetting the RAM itself.
    assign s_axis_tready = (state_q == FILL);
    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = valid_q ? ram_bus.rd_data : 32'd0;
    assign m_axis_tlast  = last_q;
    assign m_axis_tkeep  = AXIS_TKEEP;

    always_comb begin
        state_d      = state_q;
        nfft_d       = nfft_q;
        cp_d         = cp_q;
        sym_last_d   = sym_last_q;
        sym_cnt_d    = sym_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        issue_done_d = issue_done_q;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        rd_ptr       = '0;

        // The output stage may take a new beat when it is empty or its
        // current beat is being accepted; otherwise everything holds.
        adv     = !valid_q || m_axis_tready;
        valid_d = adv ? 1'b0 : valid_q;
        last_d  = adv ? 1'b0 : last_q;

        unique case (state_q)
            IDLE: begin
                if (i_nfft != '0) begin
                    nfft_d     = i_nfft;
                    cp_d       = clamp_cp(i_cp_len, i_nfft);
                    sym_last_d = i_symbols;
                    sym_cnt_d  = '0;
                    wr_cnt_d   = '0;
                    state_d    = FILL;
                end
            end

            FILL: begin
                if (s_axis_tvalid) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == nfft_q - NFFT_W'(1)) begin
                        wr_cnt_d     = '0;
                        rd_cnt_d     = '0;
                        issue_done_d = 1'b0;
                        state_d      = (cp_q == '0) ? BODY : CP;
                    end else begin
                        wr_cnt_d = wr_cnt_q + NFFT_W'(1);
                    end
                end
            end

            CP: begin
                if (adv) begin
                    rd_en   = 1'b1;
                    rd_ptr  = nfft_q - cp_q + rd_cnt_q;
                    valid_d = 1'b1;
                    if (rd_cnt_q == cp_q - NFFT_W'(1)) begin
                        rd_cnt_d = '0;
                        state_d  = BODY;
                    end else begin
                        rd_cnt_d = rd_cnt_q + NFFT_W'(1);
                    end
                end
            end

            BODY: begin
                if (adv) begin
                    if (!issue_done_q) begin
                        rd_en   = 1'b1;
                        rd_ptr  = rd_cnt_q;
                        valid_d = 1'b1;
                        last_d  = (rd_cnt_q == nfft_q - NFFT_W'(1)) &&
                                  (sym_cnt_q == sym_last_q);
                        if (rd_cnt_q == nfft_q - NFFT_W'(1)) begin
                            issue_done_d = 1'b1;
                        end else begin
                            rd_cnt_d = rd_cnt_q + NFFT_W'(1);
                        end
                    end else begin
                        // Final body beat leaves the output stage this cycle;
                        // only now may the buffer be refilled or the frame end,
                        // so tvalid is never seen high in FILL or IDLE.
                        issue_done_d = 1'b0;
                        rd_cnt_d     = '0;
                        if (sym_cnt_q == sym_last_q) begin
                            state_d = IDLE;
                        end else begin
                            sym_cnt_d = sym_cnt_q + SYM_W'(1);
                            wr_cnt_d  = '0;
                            state_d   = FILL;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q      <= IDLE;
            nfft_q       <= '0;
            cp_q         <= '0;
            sym_last_q   <= '0;
            sym_cnt_q    <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            issue_done_q <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            nfft_q       <= nfft_d;
            cp_q         <= cp_d;
            sym_last_q   <= sym_last_d;
            sym_cnt_q    <= sym_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            issue_done_q <= issue_done_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
        end
    end

`ifdef TX_FRAMER_DEBUG_EN
    assign o_dbg_state   = state_q;
    assign o_dbg_sym_cnt = sym_cnt_q;
`endif

endmodule

// File: tb/tb_tx_framer.sv
// tb/tb_tx_framer.sv - randomized self-checking bench for tx_framer
module tb_tx_framer;

    logic        axis_aclk = 1'b0;
    logic        axis_rst;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [3:0]  m_axis_tkeep;
    logic [11:0] i_nfft;
    logic [11:0] i_cp_len;
    logic [3:0]  i_symbols;
`ifdef TX_FRAMER_DEBUG_EN
    logic [1:0]  o_dbg_state;
    logic [3:0]  o_dbg_sym_cnt;
`endif

    always #5 axis_aclk = ~axis_aclk;

    tx_framer #(
        .G_ADDR_W (12)
    ) dut (
        .axis_aclk     (axis_aclk),
        .axis_rst      (axis_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .m_axis_tkeep  (m_axis_tkeep),
        .i_nfft        (i_nfft),
        .i_cp_len      (i_cp_len),
        .i_symbols     (i_symbols)
`ifdef TX_FRAMER_DEBUG_EN
        ,
        .o_dbg_state   (o_dbg_state),
        .o_dbg_sym_cnt (o_dbg_sym_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] in_q[$];
    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic        exp_end[$];
    logic [31:0] obs_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_obs(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] got;
        got = (idx < obs_q.size()) ? obs_q[idx] : 32'hDEAD_BEEF;
        check_eq(tag, got, exp);
    endtask

    // Reference: per symbol, the last min(cp,nfft) samples then all nfft samples.
    task automatic build_model(input int nfft, input int cp, input int syms);
        int cpc;
        cpc = (cp > nfft) ? nfft : cp;
        exp_data.delete();
        exp_last.delete();
        exp_end.delete();
        for (int s = 0; s <= syms; s++) begin
            for (int k = nfft - cpc; k < nfft; k++) begin
                exp_data.push_back(in_q[s * nfft + k]);
                exp_last.push_back(1'b0);
                exp_end.push_back(1'b0);
            end
            for (int k = 0; k < nfft; k++) begin
                exp_data.push_back(in_q[s * nfft + k]);
                exp_last.push_back(s == syms && k == nfft - 1);
                exp_end.push_back(k == nfft - 1);
            end
        end
    endtask

    task automatic idle_check(input int cycles, input string tag);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge axis_aclk);
            if (s_axis_tready || m_axis_tvalid) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    task automatic run_frame(input int nfft, input int cp, input int syms, input bit rand_ready,
                             input bit rand_data, input int abort_after, output int beats);
        int total, idx, cyc, fill_cyc, bubbles, fill_viol;
        bit first_seen, in_sym, stalled, held_last;
        logic [31:0] held_data;
        total = (syms + 1) * nfft;
        in_q.delete();
        obs_q.delete();
        for (int i = 0; i < total; i++) in_q.push_back(rand_data ? $urandom : 32'(i + 1));
        build_model(nfft, cp, syms);
        idx = 0; beats = 0; cyc = 0; fill_cyc = -1; bubbles = 0; fill_viol = 0;
        first_seen = 0; in_sym = 0; stalled = 0; held_data = '0; held_last = 0;
        @(negedge axis_aclk);
        i_nfft    = 12'(nfft);
        i_cp_len  = 12'(cp);
        i_symbols = 4'(syms);
        while (beats < exp_data.size() && cyc < 5000) begin
            @(negedge axis_aclk);
            if (stalled) begin
                check_eq("stall_tvalid", m_axis_tvalid, 1);
                check_eq("stall_tdata", m_axis_tdata, held_data);
                check_eq("stall_tlast", m_axis_tlast, held_last);
            end
            if (s_axis_tready && m_axis_tvalid) fill_viol++;
            if (fill_cyc >= 0 && !first_seen && (m_axis_tvalid || cyc - fill_cyc > 2)) begin
                check_eq("first_beat_latency", 32'(cyc - fill_cyc <= 2), 1);
                first_seen = 1;
                in_sym     = 1;
            end
            if (in_sym && !m_axis_tvalid && !rand_ready) bubbles++;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tvalid = (idx < total) && ($urandom_range(0, 3) != 0);
            s_axis_tdata  = (idx < total) ? in_q[idx] : $urandom;
            if (idx > 0) begin
                i_nfft    = 12'($urandom_range(1, 15));
                i_cp_len  = 12'($urandom);
                i_symbols = 4'($urandom);
            end
            if (s_axis_tready && s_axis_tvalid) begin
                idx++;
                if (idx % nfft == 0) begin
                    fill_cyc   = cyc;
                    first_seen = 0;
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                obs_q.push_back(m_axis_tdata);
                check_eq("beat_tdata", m_axis_tdata, exp_data[beats]);
                check_eq("beat_tlast", m_axis_tlast, exp_last[beats]);
                if (exp_end[beats]) in_sym = 0;
                beats++;
                if (beats == exp_data.size()) i_nfft = '0;
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
            cyc++;
            if (abort_after > 0 && beats == abort_after) break;
        end
        s_axis_tvalid = 1'b0;
        if (abort_after == 0) begin
            check_eq("frame_beats", beats, exp_data.size());
            check_eq("tvalid_in_fill", fill_viol, 0);
            if (!rand_ready) check_eq("sustained_rate", bubbles, 0);
            idle_check(3, "idle_after_frame");
        end else begin
            check_eq("abort_reached", beats, abort_after);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        axis_rst      = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        i_nfft        = '0;
        i_cp_len      = '0;
        i_symbols     = '0;
        repeat (2) @(negedge axis_aclk);
        check_eq("rst_tvalid", m_axis_tvalid, 0);
        check_eq("rst_s_tready", s_axis_tready, 0);
        check_eq("rst_tlast", m_axis_tlast, 0);
        check_eq("rst_tdata", m_axis_tdata, 0);
        check_eq("tkeep", m_axis_tkeep, 4'hF);
        axis_rst = 1'b0;

        // nfft=0: nothing accepted, nothing produced
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h1234_5678;
        i_cp_len      = 12'd5;
        i_symbols     = 4'd2;
        m_axis_tready = 1'b1;
        idle_check(20, "nfft0_idle");
        s_axis_tvalid = 1'b0;

        run_frame(8, 3, 1, 0, 0, 0, b);
        check_eq("basic_beats", b, 22);
        check_obs("basic_b1", 0, 6);
        check_obs("basic_b3", 2, 8);
        check_obs("basic_b4", 3, 1);
        check_obs("basic_b12", 11, 14);
        check_obs("basic_b15", 14, 9);
        check_obs("basic_b22", 21, 16);

        run_frame(4, 0, 0, 0, 0, 0, b);
        check_eq("nocp_beats", b, 4);
        check_obs("nocp_b1", 0, 1);
        check_obs("nocp_b4", 3, 4);

        run_frame(4, 10, 0, 0, 0, 0, b);
        check_eq("clamp_beats", b, 8);
        check_obs("clamp_b1", 0, 1);
        check_obs("clamp_b5", 4, 1);
        check_obs("clamp_b8", 7, 4);

        run_frame(8, 3, 1, 1, 0, 0, b);
        check_eq("stall_beats", b, 22);
        check_obs("stall_b1", 0, 6);
        check_obs("stall_b22", 21, 16);

        // reset during body of symbol 0 (3 CP + 2 body beats already sent)
        run_frame(8, 3, 1, 0, 0, 5, b);
        @(negedge axis_aclk);
        check_eq("pre_rst_busy", m_axis_tvalid, 1);
        axis_rst = 1'b1;
        i_nfft   = '0;
        #1;
        check_eq("rst_mid_tvalid", m_axis_tvalid, 0);
        check_eq("rst_mid_s_tready", s_axis_tready, 0);
        check_eq("rst_mid_tlast", m_axis_tlast, 0);
        check_eq("rst_mid_tdata", m_axis_tdata, 0);
        @(negedge axis_aclk);
        check_eq("rst_next_tvalid", m_axis_tvalid, 0);
        check_eq("rst_next_s_tready", s_axis_tready, 0);
        axis_rst = 1'b0;
        run_frame(8, 3, 1, 0, 0, 0, b);
        check_eq("post_rst_beats", b, 22);
        check_obs("post_rst_b1", 0, 6);

        for (int f = 0; f < 10; f++) begin
            run_frame($urandom_range(1, 16), $urandom_range(0, 20), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'b1, 0, b);
        end

        s_axis_tvalid = 1'b1;
        idle_check(10, "nfft0_idle_end");
        s_axis_tvalid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
